// File: rtl/onchip_mem_rr_arbiter.sv
// Two-master round-robin arbiter sharing the single-port on-chip RAM between m0 and m1.
// Optional grant-hold (lock) support is compiled in when ONCHIP_ARB_LOCK_EN is defined.
module onchip_mem_rr_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_lock,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_lock,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int BE_W = DATA_W / 8;

  logic req0, req1;
  logic rr_valid, rr_sel;
  logic gnt_valid, gnt_sel, gnt_write;
  logic last_gnt;
  logic rd_vld_q, rd_owner_q;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [BE_W-1:0]   be_hold_q;
  logic [DATA_W-1:0] wdata_hold_q;

  assign req0     = m0_read | m0_write;
  assign req1     = m1_read | m1_write;
  assign rr_valid = req0 | req1;
  // On a tie the master that did not win last time goes first.
  assign rr_sel   = (req0 && req1) ? ~last_gnt : req1;

`ifdef ONCHIP_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic             lock_on_q, lock_owner_q;
  logic [CNT_W-1:0] lock_cnt_q;
  logic             owner_lock, owner_req, other_req, gnt_lock;
  logic             lock_hold, lock_break;

  assign owner_lock = lock_owner_q ? m1_lock : m0_lock;
  assign owner_req  = lock_owner_q ? req1 : req0;
  assign other_req  = lock_owner_q ? req0 : req1;
  assign lock_hold  = lock_on_q & owner_lock & (lock_cnt_q <  CNT_W'(LOCK_MAX));
  assign lock_break = lock_on_q & owner_lock & (lock_cnt_q >= CNT_W'(LOCK_MAX));
  assign gnt_lock   = gnt_sel ? m1_lock : m0_lock;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_sel   = rr_sel;
    if (!reset) begin
      if (lock_hold) begin
        gnt_valid = owner_req;
        gnt_sel   = lock_owner_q;
      end else if (lock_break && other_req) begin
        gnt_valid = 1'b1;
        gnt_sel   = ~lock_owner_q;
      end else begin
        gnt_valid = rr_valid;
      end
    end
  end

  // A broken lock never re-engages in its own break cycle, so the other master gets through.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_on_q    <= 1'b0;
      lock_owner_q <= 1'b0;
      lock_cnt_q   <= '0;
    end else if (lock_hold) begin
      lock_cnt_q <= lock_cnt_q + 1'b1;
    end else if (lock_break) begin
      lock_on_q  <= 1'b0;
      lock_cnt_q <= '0;
    end else if (gnt_valid && gnt_lock) begin
      lock_on_q    <= 1'b1;
      lock_owner_q <= gnt_sel;
      lock_cnt_q   <= CNT_W'(1);
    end else begin
      lock_on_q  <= 1'b0;
      lock_cnt_q <= '0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = m0_lock | m1_lock | (LOCK_MAX == 0);

  always_comb begin
    gnt_valid = ~reset & rr_valid;
    gnt_sel   = rr_sel;
  end
`endif

  assign gnt_write = gnt_sel ? m1_write : m0_write;

  assign m0_waitrequest = ~(gnt_valid & ~gnt_sel);
  assign m1_waitrequest = ~(gnt_valid &  gnt_sel);

  assign mem_clken      = 1'b1;
  assign mem_chipselect = gnt_valid;
  assign mem_write      = gnt_valid & gnt_write;
  assign mem_address    = !gnt_valid ? addr_hold_q  : (gnt_sel ? m1_address    : m0_address);
  assign mem_byteenable = !gnt_valid ? be_hold_q    : (gnt_sel ? m1_byteenable : m0_byteenable);
  assign mem_writedata  = !gnt_valid ? wdata_hold_q : (gnt_sel ? m1_writedata  : m0_writedata);

  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_vld_q & ~rd_owner_q & ~reset;
  assign m1_readdatavalid = rd_vld_q &  rd_owner_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt   <= 1'b1;
      rd_vld_q   <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      if (gnt_valid) begin
        last_gnt <= gnt_sel;
      end
      rd_vld_q   <= gnt_valid & ~gnt_write;
      rd_owner_q <= gnt_sel;
    end
  end

  // The RAM bus keeps the last granted command on idle cycles.
  always_ff @(posedge clk) begin
    if (gnt_valid) begin
      addr_hold_q  <= gnt_sel ? m1_address    : m0_address;
      be_hold_q    <= gnt_sel ? m1_byteenable : m0_byteenable;
      wdata_hold_q <= gnt_sel ? m1_writedata  : m0_writedata;
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(m0_read && m0_write)) else $error("m0 asserted read and write together");
      assert (!(m1_read && m1_write)) else $error("m1 asserted read and write together");
    end
  end

endmodule
